// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Issues word-aligned fetch requests over a
//   valid/ready handshake to an instruction memory whose responses come back
//   in order with variable latency. Returned words are buffered with their PCs
//   in a FIFO and handed to decode over valid/ready. A redirect flushes the
//   buffer, restarts fetch at the new target and discards every response that
//   is still in flight.
//
//   Issue credit: a request is only issued while (buffered + outstanding) is
//   below FIFO_DEPTH, so every response always has a free buffer slot.
//
// Parameters
//   XLEN        PC / address width
//   RESET_PC    first fetch address after reset (multiple of 4)
//   FIFO_DEPTH  buffer entries, power of 2 and >= 2; also caps outstanding
//
// Ports
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_redirect, i_redirect_pc  flush and restart at target (bits [1:0] ignored)
//   o_imem_req_vld, i_imem_req_rdy, o_imem_addr   fetch request channel
//   i_imem_rsp_vld, i_imem_rsp_data               in-order response channel
//   o_insn_vld, i_insn_rdy, o_insn, o_insn_pc      decode-side FIFO head
//   o_pcDebug               head PC when valid, otherwise the fetch PC
//
// Optional feature (macro FETCH_PERF_EN)
//   Adds o_perf_fetched, o_perf_dropped, o_perf_stall: 32-bit saturating
//   event counters (request handshakes, discarded responses, cycles without
//   a request outside reset/redirect).
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_vld,
    input  logic            i_imem_req_rdy,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rsp_vld,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_insn_vld,
    input  logic            i_insn_rdy,
    output logic [31:0]     o_insn,
    output logic [XLEN-1:0] o_insn_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_dropped,
    output logic [31:0]     o_perf_stall,
`endif
    output logic [XLEN-1:0] o_pcDebug
);

    localparam int              AW            = $clog2(FIFO_DEPTH);
    localparam int              CW            = AW + 1;
    localparam logic [CW-1:0]   CNT_ZERO      = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE       = CW'(1);
    localparam logic [CW-1:0]   DEPTH_CNT     = CW'(FIFO_DEPTH);
    localparam logic [CW:0]     DEPTH_EXT     = (CW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ZERO      = AW'(0);
    localparam logic [AW-1:0]   PTR_ONE       = AW'(1);
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~(XLEN'(3));

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Architectural state
    state_t            state_r;
    logic [XLEN-1:0]   fetch_pc_r;
    logic [XLEN-1:0]   rsp_pc_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     outs_r;
    logic [CW-1:0]     drop_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [31:0]       insn_mem_r [FIFO_DEPTH];
    logic [XLEN-1:0]   pc_mem_r   [FIFO_DEPTH];

    // Next-state / decode signals
    state_t            state_nxt_s;
    logic [XLEN-1:0]   fetch_pc_nxt_s;
    logic [XLEN-1:0]   rsp_pc_nxt_s;
    logic [CW-1:0]     count_nxt_s;
    logic [CW-1:0]     outs_nxt_s;
    logic [CW-1:0]     drop_nxt_s;
    logic [CW-1:0]     redirect_drop_s;
    logic [CW:0]       occupancy_s;
    logic [XLEN-1:0]   redirect_target_s;
    logic              req_vld_s;
    logic              hs_s;
    logic              rsp_acc_s;
    logic              push_s;
    logic              pop_s;
    logic              insn_vld_s;
    logic              discard_s;

    assign redirect_target_s = i_redirect_pc & PC_ALIGN_MASK;
    assign insn_vld_s        = (count_r != CNT_ZERO);

    // A response is only meaningful while something is outstanding; stale
    // responses (e.g. from before a reset) are ignored.
    assign rsp_acc_s = i_imem_rsp_vld && (outs_r != CNT_ZERO) && !i_reset;
    assign hs_s      = req_vld_s && i_imem_req_rdy;
    assign push_s    = rsp_acc_s && !i_redirect && !discard_s;
    assign pop_s     = insn_vld_s && i_insn_rdy && !i_redirect;

    // Everything still in flight after this edge belongs to the old stream,
    // so after a redirect the drop count equals the surviving outstanding
    // count (a response arriving in the redirect cycle is discarded here).
    assign redirect_drop_s = rsp_acc_s ? (outs_r - CNT_ONE) : outs_r;

    // Request issue: credit check against buffered plus outstanding entries
    always_comb begin
        occupancy_s = {1'b0, count_r} + {1'b0, outs_r};
        if (i_reset || i_redirect) begin
            req_vld_s = 1'b0;
        end else begin
            req_vld_s = (occupancy_s < DEPTH_EXT);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: S_DRAIN while stale responses remain to discard
    always_comb begin
        state_nxt_s = state_r;
        if (i_redirect) begin
            if (redirect_drop_s != CNT_ZERO) begin
                state_nxt_s = S_DRAIN;
            end else begin
                state_nxt_s = S_RUN;
            end
        end else begin
            case (state_r)
                S_RUN: begin
                    state_nxt_s = S_RUN;
                end
                S_DRAIN: begin
                    if (rsp_acc_s && (drop_r == CNT_ONE)) begin
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = S_RUN;
                end
            endcase
        end
    end

    // FSM output decode: responses are discarded while draining
    always_comb begin
        case (state_r)
            S_RUN:   discard_s = 1'b0;
            S_DRAIN: discard_s = 1'b1;
            default: discard_s = 1'b0;
        endcase
    end

    // Counter and PC next-state computation
    always_comb begin
        count_nxt_s    = count_r;
        outs_nxt_s     = outs_r;
        drop_nxt_s     = drop_r;
        fetch_pc_nxt_s = fetch_pc_r;
        rsp_pc_nxt_s   = rsp_pc_r;

        case ({hs_s, rsp_acc_s})
            2'b10:   outs_nxt_s = outs_r + CNT_ONE;
            2'b01:   outs_nxt_s = outs_r - CNT_ONE;
            default: outs_nxt_s = outs_r;
        endcase

        if (i_redirect) begin
            count_nxt_s    = CNT_ZERO;
            drop_nxt_s     = redirect_drop_s;
            fetch_pc_nxt_s = redirect_target_s;
            rsp_pc_nxt_s   = redirect_target_s;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase

            if (discard_s && rsp_acc_s) begin
                drop_nxt_s = drop_r - CNT_ONE;
            end else begin
                drop_nxt_s = drop_r;
            end

            if (hs_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end

            // Response PCs follow the request stream, one word per kept response
            if (push_s) begin
                rsp_pc_nxt_s = rsp_pc_r + PC_STEP;
            end else begin
                rsp_pc_nxt_s = rsp_pc_r;
            end
        end
    end

    // Counter, PC and pointer registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            count_r    <= CNT_ZERO;
            outs_r     <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            rsp_pc_r   <= rsp_pc_nxt_s;
            count_r    <= count_nxt_s;
            outs_r     <= outs_nxt_s;
            drop_r     <= drop_nxt_s;
            if (i_redirect) begin
                rd_ptr_r <= PTR_ZERO;
                wr_ptr_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
        end
    end

    // Buffer storage: data/PC pairs, written at the tail on each kept response
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            insn_mem_r[wr_ptr_r] <= i_imem_rsp_data;
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
        end
    end

    assign o_imem_req_vld = req_vld_s;
    assign o_imem_addr    = fetch_pc_r;
    assign o_insn_vld     = insn_vld_s;
    assign o_insn         = insn_vld_s ? insn_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign o_insn_pc      = insn_vld_s ? pc_mem_r[rd_ptr_r]   : XLEN'(0);
    assign o_pcDebug      = insn_vld_s ? pc_mem_r[rd_ptr_r]   : fetch_pc_r;

`ifdef FETCH_PERF_EN
    logic        rsp_drop_s;
    logic        stall_s;
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_dropped_r;
    logic [31:0] perf_stall_r;

    assign rsp_drop_s = rsp_acc_s && (i_redirect || discard_s);
    assign stall_s    = !req_vld_s && !i_reset && !i_redirect;

    // Saturating performance counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_dropped_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
        end else begin
            if (hs_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (rsp_drop_s && (perf_dropped_r != 32'hFFFF_FFFF)) begin
                perf_dropped_r <= perf_dropped_r + 32'd1;
            end
            if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign o_perf_fetched = perf_fetched_r;
    assign o_perf_dropped = perf_dropped_r;
    assign o_perf_stall   = perf_stall_r;
`endif

    // Structural invariants of the credit scheme
    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
        !(push_s && (count_r == DEPTH_CNT)));
    a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        (count_r <= DEPTH_CNT) && (outs_r <= DEPTH_CNT));
    a_drop_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        drop_r <= outs_r);

endmodule
